// File: rtl/morse_tx_scheduler.sv
// morse_tx_scheduler
// Queues translated Morse characters and plays them out on Y one unit at a
// time, inserting the inter-character gap after each symbol and a word gap
// for length-0 (space) entries.
//
// Ports:
//   CLK, RST            clock and synchronous active-high reset
//   abort               (only with MORSE_ABORT_EN) stop playback and flush
//   wr_valid/wr_ready   push handshake for the character queue
//   wr_pattern, wr_len  left-aligned unit pattern and its length (0 = space)
//   Start               begin playback of queued characters (from IDLE)
//   Y                   registered Morse output
//   busy                high whenever the scheduler is not IDLE
//   char_done           one-cycle pulse when a character's trailing gap ends
//   count               current queue occupancy
//
// Optional feature macro: MORSE_ABORT_EN adds the abort input.
module morse_tx_scheduler #(
  parameter int DEPTH       = 16,
  parameter int PAT_W       = 22,
  parameter int LEN_W       = 5,
  parameter int UNIT_CYCLES = 10000000,
  parameter int GAP_CHAR    = 3,
  parameter int GAP_WORD    = 7
) (
  input  logic             CLK,
  input  logic             RST,
`ifdef MORSE_ABORT_EN
  input  logic             abort,
`endif
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [PAT_W-1:0] wr_pattern,
  input  logic [LEN_W-1:0] wr_len,
  input  logic             Start,
  output logic             Y,
  output logic             busy,
  output logic             char_done,
  output logic [LEN_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = $clog2(UNIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, SYMBOL, GAP} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PAT_W-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]   units_left_q, units_left_d;
  logic [UW-1:0]      unit_cnt_q, unit_cnt_d;
  logic               y_q, y_d, busy_q, busy_d, char_done_q, char_done_d;

  logic [PAT_W+LEN_W-1:0] mem_q [DEPTH];
  logic [PAT_W+LEN_W-1:0] head_entry;
  logic [PAT_W-1:0]       head_pat;
  logic [LEN_W-1:0]       head_len, head_len_clamped;
  logic                   abort_w, push, pop, unit_end, last_unit;

`ifdef MORSE_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // No bypass: a full queue refuses pushes even when a pop happens that cycle.
  assign wr_ready  = (count_q < CW'(DEPTH));
  assign push      = wr_valid && wr_ready && !abort_w;
  assign pop       = (state_q == LOAD) && !abort_w;
  assign unit_end  = (unit_cnt_q == UW'(UNIT_CYCLES - 1));
  assign last_unit = unit_end && (units_left_q == LEN_W'(1));

  assign head_entry       = mem_q[rd_ptr_q];
  assign head_pat         = head_entry[PAT_W+LEN_W-1:LEN_W];
  assign head_len         = head_entry[LEN_W-1:0];
  assign head_len_clamped = (head_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : head_len;

  // Queue storage: written on push, no reset needed (pointers define validity).
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {wr_pattern, wr_len};
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    units_left_d = units_left_q;
    unit_cnt_d   = unit_cnt_q;
    char_done_d  = 1'b0;
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);

    case (state_q)
      IDLE: begin
        if (Start && (count_q != '0)) state_d = LOAD;
      end
      LOAD: begin
        unit_cnt_d = '0;
        if (head_len != '0) begin
          shift_d      = head_pat;
          units_left_d = head_len_clamped;
          state_d      = SYMBOL;
        end else begin
          units_left_d = LEN_W'(GAP_WORD);
          state_d      = GAP;
        end
      end
      SYMBOL: begin
        if (unit_end) begin
          unit_cnt_d   = '0;
          shift_d      = shift_q << 1;
          units_left_d = units_left_q - LEN_W'(1);
          if (last_unit) begin
            units_left_d = LEN_W'(GAP_CHAR);
            state_d      = GAP;
          end
        end else begin
          unit_cnt_d = unit_cnt_q + UW'(1);
        end
      end
      GAP: begin
        if (unit_end) begin
          unit_cnt_d   = '0;
          units_left_d = units_left_q - LEN_W'(1);
          if (last_unit) begin
            char_done_d = 1'b1;
            // A push landing in this very cycle still chains straight to LOAD.
            state_d = ((count_q != '0) || push) ? LOAD : IDLE;
          end
        end else begin
          unit_cnt_d = unit_cnt_q + UW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_w) begin
      state_d     = IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      char_done_d = 1'b0;
    end

    // Outputs are registered, so Y trails the state by one cycle.
    y_d    = (state_q == SYMBOL) && shift_q[PAT_W-1] && !abort_w;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      shift_q      <= '0;
      units_left_q <= '0;
      unit_cnt_q   <= '0;
      y_q          <= 1'b0;
      busy_q       <= 1'b0;
      char_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      units_left_q <= units_left_d;
      unit_cnt_q   <= unit_cnt_d;
      y_q          <= y_d;
      busy_q       <= busy_d;
      char_done_q  <= char_done_d;
    end
  end

  assign Y         = y_q;
  assign busy      = busy_q;
  assign char_done = char_done_q;
  assign count     = LEN_W'(count_q);

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Testbench for morse_tx_scheduler (UNIT_CYCLES=4). Expected Y / char_done /
// busy waveforms come from a unit-level model of the queued characters.
module tb_morse_tx_scheduler;

  localparam int UC = 4;
  localparam int GC = 3;
  localparam int GW = 7;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [21:0] wr_pattern = '0;
  logic [4:0]  wr_len = '0;
  logic        Start = 1'b0;
  logic        Y, busy, char_done;
  logic [4:0]  count;
`ifdef MORSE_ABORT_EN
  logic        abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [21:0] q_pat[$];
  logic [4:0]  q_len[$];
  logic y_exp[$], cd_exp[$], busy_exp[$];
  logic obs_y[$], obs_cd[$], obs_busy[$];

  morse_tx_scheduler #(.DEPTH(16), .PAT_W(22), .LEN_W(5), .UNIT_CYCLES(UC),
                       .GAP_CHAR(GC), .GAP_WORD(GW)) dut (
    .CLK(CLK), .RST(RST),
`ifdef MORSE_ABORT_EN
    .abort(abort),
`endif
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pattern(wr_pattern),
    .wr_len(wr_len), .Start(Start), .Y(Y), .busy(busy),
    .char_done(char_done), .count(count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: every character costs one silent load cycle, then its tone
  // units (UC cycles each), then its trailing low units. char_done marks the
  // last low cycle; busy falls on the very last cycle of the whole run.
  function automatic void build_model();
    y_exp = {}; cd_exp = {}; busy_exp = {};
    for (int e = 0; e < q_pat.size(); e++) begin
      int n, gz;
      n  = (q_len[e] > 22) ? 22 : int'(q_len[e]);
      gz = (n == 0) ? GW : GC;
      y_exp.push_back(1'b0);
      for (int i = 0; i < n; i++)
        for (int u = 0; u < UC; u++) y_exp.push_back(q_pat[e][21-i]);
      for (int u = 0; u < gz * UC; u++) y_exp.push_back(1'b0);
      while (cd_exp.size() < y_exp.size()) cd_exp.push_back(1'b0);
      cd_exp[cd_exp.size()-1] = 1'b1;
    end
    for (int j = 0; j < y_exp.size(); j++) busy_exp.push_back(j < y_exp.size() - 1);
  endfunction

  function automatic int first_diff(input logic a[$], input logic b[$]);
    if (a.size() != b.size()) return 0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic push_one(input logic [21:0] p, input logic [4:0] l);
    wr_valid = 1'b1; wr_pattern = p; wr_len = l;
    @(negedge CLK);
    wr_valid = 1'b0;
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  // Record n cycles of outputs; at sample act_at also push (ap,al) and pulse Start.
  task automatic capture(input int n, input int act_at, input logic [21:0] ap, input logic [4:0] al);
    obs_y = {}; obs_cd = {}; obs_busy = {};
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      obs_y.push_back(Y); obs_cd.push_back(char_done); obs_busy.push_back(busy);
      wr_valid = (k == act_at); Start = (k == act_at);
      wr_pattern = ap; wr_len = al;
    end
    wr_valid = 1'b0; Start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    checks++; if ({Y, busy, char_done} !== 3'b000) begin errors++; $display("FAIL reset_outs: got Y/busy/cd=%b want 000", {Y, busy, char_done}); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", wr_ready); end
    start_pulse();
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_empty: busy got %b want 0", busy); end
    for (int i = 0; i < 3; i++) push_one(22'h3FFFFF, 5'd5);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL push3_count: got %0d want 3", count); end
    start_pulse();
    repeat (2) @(negedge CLK);
    checks++; if ({Y, busy, count} !== {1'b1, 1'b1, 5'd2}) begin errors++; $display("FAIL playing: Y/busy/count got %b/%b/%0d want 1/1/2", Y, busy, count); end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++; if ({Y, busy, count, wr_ready} !== {1'b0, 1'b0, 5'd0, 1'b1}) begin errors++; $display("FAIL midreset: Y/busy/count/ready got %b/%b/%0d/%b want 0/0/0/1", Y, busy, count, wr_ready); end
    start_pulse();
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL queue_discarded: busy got %b want 0", busy); end
  endtask

  task automatic test_single_e();
    int d;
    q_pat = {22'h200000}; q_len = {5'd1};
    push_one(22'h200000, 5'd1);
    build_model();
    start_pulse();
    capture(y_exp.size(), -1, '0, '0);
    d = first_diff(obs_y, y_exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL e_y: at cycle %0d got %b want %b", d, obs_y[d], y_exp[d]); end
    d = first_diff(obs_cd, cd_exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL e_char_done: at cycle %0d got %b want %b", d, obs_cd[d], cd_exp[d]); end
    d = first_diff(obs_busy, busy_exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL e_busy: at cycle %0d got %b want %b", d, obs_busy[d], busy_exp[d]); end
  endtask

  task automatic test_word_space();
    int d;
    q_pat = {22'h2E0000, 22'h000000}; q_len = {5'd5, 5'd0};
    foreach (q_pat[i]) push_one(q_pat[i], q_len[i]);
    build_model();
    start_pulse();
    capture(y_exp.size(), -1, '0, '0);
    d = first_diff(obs_y, y_exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL space_y: at cycle %0d got %b want %b", d, obs_y[d], y_exp[d]); end
    d = first_diff(obs_cd, cd_exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL space_char_done: at cycle %0d got %b want %b", d, obs_cd[d], cd_exp[d]); end
    d = first_diff(obs_busy, busy_exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL space_busy: at cycle %0d got %b want %b", d, obs_busy[d], busy_exp[d]); end
  endtask

  task automatic test_random();
    int d, n;
    for (int r = 0; r < 4; r++) begin
      q_pat = {}; q_len = {};
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        q_pat.push_back(22'($urandom));
        q_len.push_back(5'($urandom_range(0, 25)));
      end
      foreach (q_pat[i]) push_one(q_pat[i], q_len[i]);
      build_model();
      start_pulse();
      capture(y_exp.size(), -1, '0, '0);
      d = first_diff(obs_y, y_exp);
      checks++; if (d >= 0) begin errors++; $display("FAIL rand%0d_y: at cycle %0d got %b want %b", r, d, obs_y[d], y_exp[d]); end
      d = first_diff(obs_cd, cd_exp);
      checks++; if (d >= 0) begin errors++; $display("FAIL rand%0d_char_done: at cycle %0d got %b want %b", r, d, obs_cd[d], cd_exp[d]); end
      d = first_diff(obs_busy, busy_exp);
      checks++; if (d >= 0) begin errors++; $display("FAIL rand%0d_busy: at cycle %0d got %b want %b", r, d, obs_busy[d], busy_exp[d]); end
    end
  endtask

  task automatic test_full();
    int d;
    logic [21:0] p;
    logic [4:0]  l;
    q_pat = {}; q_len = {};
    for (int i = 0; i < 17; i++) begin
      p = 22'($urandom) | 22'h200000;
      l = 5'($urandom_range(1, 3));
      if (i < 16) begin q_pat.push_back(p); q_len.push_back(l); end
      push_one(p, l);
      if (i == 15) begin
        checks++; if ({wr_ready, count} !== {1'b0, 5'd16}) begin errors++; $display("FAIL full_16: ready/count got %b/%0d want 0/16", wr_ready, count); end
      end
    end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_drop: count got %0d want 16", count); end
    build_model();
    start_pulse();
    capture(y_exp.size(), -1, '0, '0);
    d = first_diff(obs_y, y_exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL full_y: at cycle %0d got %b want %b", d, obs_y[d], y_exp[d]); end
    d = first_diff(obs_cd, cd_exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL full_char_done: at cycle %0d got %b want %b", d, obs_cd[d], cd_exp[d]); end
    checks++; if ({count, wr_ready} !== {5'd0, 1'b1}) begin errors++; $display("FAIL full_drain: count/ready got %0d/%b want 0/1", count, wr_ready); end
  endtask

  task automatic test_back_to_back();
    int d;
    // 'A' gap occupies samples 20..31; push 'E' and pulse Start at sample 25.
    q_pat = {22'h2E0000, 22'h200000}; q_len = {5'd5, 5'd1};
    push_one(q_pat[0], q_len[0]);
    build_model();
    start_pulse();
    capture(y_exp.size(), 25, q_pat[1], q_len[1]);
    d = first_diff(obs_y, y_exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL b2b_y: at cycle %0d got %b want %b", d, obs_y[d], y_exp[d]); end
    d = first_diff(obs_cd, cd_exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL b2b_char_done: at cycle %0d got %b want %b", d, obs_cd[d], cd_exp[d]); end
    d = first_diff(obs_busy, busy_exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL b2b_busy: at cycle %0d got %b want %b", d, obs_busy[d], busy_exp[d]); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL b2b_count: got %0d want 0", count); end
  endtask

`ifdef MORSE_ABORT_EN
  task automatic test_abort();
    int pulses;
    for (int i = 0; i < 5; i++) push_one(22'h3FFFFF, 5'd5);
    start_pulse();
    repeat (5) @(negedge CLK);
    checks++; if (Y !== 1'b1) begin errors++; $display("FAIL abort_pre: Y got %b want 1", Y); end
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    checks++; if ({Y, busy, count, char_done} !== {1'b0, 1'b0, 5'd0, 1'b0}) begin errors++; $display("FAIL abort: Y/busy/count/cd got %b/%b/%0d/%b want 0/0/0/0", Y, busy, count, char_done); end
    pulses = 0;
    repeat (40) begin @(negedge CLK); if (char_done === 1'b1 || busy !== 1'b0) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", pulses); end
  endtask
`endif

  initial begin
    @(negedge CLK);
    test_reset();
    test_single_e();
    test_word_space();
    test_random();
    test_full();
    test_back_to_back();
`ifdef MORSE_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
